// File: rtl/demux_sequencer.sv
// ============================================================================
// demux_sequencer: registered 1-to-4 demux with per-channel holding registers.
// Optional DEMUX_OVERFLOW_COUNT_EN enables the saturating rejected-transfer counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module demux_sequencer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             address0,
    input  logic             address1,
    input  logic             auto,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic             out_valid3,
    input  logic             out_ack0,
    input  logic             out_ack1,
    input  logic             out_ack2,
    input  logic             out_ack3,
    output logic [7:0]       overflow_count
);

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q, valid_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       ack;
    logic [1:0]       sel;
    logic             xfer;

    assign ack      = {out_ack3, out_ack2, out_ack1, out_ack0};
    assign sel      = auto ? ptr_q : {address1, address0};
    assign in_ready = !valid_q[sel] || ack[sel];
    assign xfer     = in_valid && in_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~ack;
        ptr_d   = ptr_q;
        // A write to a channel overrides a same-edge drain of that channel.
        for (int i = 0; i < 4; i++) begin
            if (xfer && (sel == 2'(i))) begin
                data_d[i]  = in;
                valid_d[i] = 1'b1;
            end
        end
        if (auto && xfer) begin
            ptr_d = ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= 4'b0000;
            ptr_q   <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out0       = data_q[0];
    assign out1       = data_q[1];
    assign out2       = data_q[2];
    assign out3       = data_q[3];
    assign out_valid0 = valid_q[0];
    assign out_valid1 = valid_q[1];
    assign out_valid2 = valid_q[2];
    assign out_valid3 = valid_q[3];

`ifdef DEMUX_OVERFLOW_COUNT_EN
    logic [7:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (in_valid && !in_ready && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 8'h00;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_count = ovf_q;
`else
    assign overflow_count = 8'h00;
`endif

endmodule

`default_nettype wire

// File: doc/demux_sequencer.md
# demux_sequencer

Registered 1-to-4 demultiplexer: the write-side counterpart of the team's 4:1 structural multiplexer. It accepts data words with a valid/ready handshake and steers each accepted word into one of four single-entry holding registers, each drained independently by its consumer with a valid/ack handshake. Channel selection comes from the two address pins (same encoding as the multiplexer) or from an internal round-robin pointer in auto mode. The block sits between a shared producer and four per-channel consumers.

## Interface
- WIDTH, 1, data width of `in` and `out0`..`out3`
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in  input  WIDTH  data word from producer
- in_valid  input  1  producer has a word on `in`
- in_ready  output  1  block accepts the word this cycle (combinational)
- address0  input  1  channel select LSB
- address1  input  1  channel select MSB; channel = 2·address1 + address0
- auto  input  1  1 = use internal pointer, ignore address pins
- out0..out3  output  WIDTH  holding register per channel
- out_valid0..out_valid3  output  1  holding register N holds an unconsumed word
- out_ack0..out_ack3  input  1  consumer N takes the word this cycle
- overflow_count  output  8  rejected-transfer counter (see Configuration)

## Operation
- sel = auto ? ptr : {address1,address0}. ptr: 2-bit register, reset 0.
- in_ready = !out_valid[sel] || out_ack[sel]. Independent of `in_valid`.
- Transfer: in_valid && in_ready at rising edge → out[sel] ← in, out_valid[sel] ← 1.
- Auto mode: each transfer increments ptr, 3 wraps to 0. No transfer → ptr holds. ptr not updated when auto = 0; switching auto resumes from held ptr.
- Drain: out_ackN && out_validN → out_validN ← 0, unless the same edge writes channel N (then stays 1, outN takes the new word).
- out_ackN with out_validN = 0: ignored.
- outN holds last written value after drain; consumers qualify with out_validN.
- Channels drain independently; a full channel never blocks writes to others.
- A rejected cycle (in_valid && !in_ready) changes no state apart from overflow_count; producer holds `in`.
- Only `in` is stored; address pins and auto are sampled only at the transfer edge.

## Timing
- Reset values: out0..out3 = 0, out_valid0..3 = 0, ptr = 0, overflow_count = 0; in_ready = 1 during and after reset.
- reset asserted mid-operation: all held words discarded asynchronously, no pending ack honoured.
- Latency: word accepted at edge k → visible on outN with out_validN = 1 after edge k (1 cycle).
- Full-throughput: one word per cycle into one channel sustainable when its consumer acks every cycle (write + ack same edge).
- in_ready is combinational from registered state, sel, and out_ack; no combinational path from in_valid.

## Configuration
- DEMUX_OVERFLOW_COUNT_EN defined: overflow_count increments by 1 at each edge where in_valid && !in_ready, saturating at 255; cleared only by reset.
- Not defined: counter logic omitted, overflow_count tied to 8'h00. Port list identical in both builds.

## Test plan
- Reset, then address1=0 address0=1, in=1, in_valid=1 for one cycle → after edge: out1=1, out_valid1=1, all other out_validN=0, in_ready still 1 for sel=0.
- Fill channel 2 (address1=1, address0=0), hold in_valid with no ack for 3 cycles → in_ready=0, out2 unchanged; with macro, overflow_count=3; without, 0.
- Channel 3 full, drive out_ack3=1 and new word (WIDTH=8: 8'hA5) same cycle → in_ready=1, after edge out3=8'hA5, out_valid3=1.
- auto=1, 5 consecutive transfers 8'h01..8'h05 with all acks asserted → written to channels 0,1,2,3,0; out0=8'h05, ptr=1.
- Fill channels 0 and 1, assert reset between clock edges → all out_validN=0, outN=0, overflow_count=0 immediately, before next edge.
- Channel 0 full, producer targets channel 1 → accepted; out_ack0 with out_valid0=0 afterwards → no state change.
